// File: rtl/playback_controller.sv
// Playback controller for a colour-sequence memory game.
// Each round appends a random colour to an external history and plays the
// sequence back oldest first (SHOW lit, GAP dark). It then checks the
// player's presses in the same order and ends in WIN after MAX_LEN rounds,
// or in LOSE on a wrong press or an idle timeout.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start           : level request to begin a new game (IDLE/WIN/LOSE only)
//   segment         : colour history, slot 1 newest, slot k k-th newest
//   rand_colour     : colour appended on the next ADD
//   btn_valid       : single-cycle press strobe, btn_colour its colour
//   seq_clear       : one-cycle history clear pulse
//   load_colour     : one-cycle append pulse, new_colour the appended value
//   led_en          : lamp enable, led_colour the lamp colour (0 when dark)
//   round           : current sequence length
//   win, lose       : held high in the terminal states
module playback_controller #(
   parameter int unsigned SHOW_CYCLES    = 25000000,
   parameter int unsigned GAP_CYCLES     = 5000000,
   parameter int unsigned TIMEOUT_CYCLES = 250000000,
   parameter int unsigned MAX_LEN        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [32:0][1:0] segment,
   input  logic [1:0]       rand_colour,
   input  logic             btn_valid,
   input  logic [1:0]       btn_colour,
   output logic             seq_clear,
   output logic             load_colour,
   output logic [1:0]       new_colour,
   output logic             led_en,
   output logic [1:0]       led_colour,
   output logic [5:0]       round,
   output logic             win,
   output logic             lose
);

   // One counter serves SHOW, GAP and the WAIT_IN timeout, so size it for the largest.
   localparam int unsigned MAX_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int unsigned MAX_CNT = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [5:0]       MAX_ROUND = 6'(MAX_LEN);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLEAR,
      S_ADD,
      S_SETTLE,
      S_SHOW,
      S_GAP,
      S_WAIT_IN,
      S_WIN,
      S_LOSE
   } state_e;

   state_e           state_q, state_d;
   logic [5:0]       round_q, round_d;
   logic [5:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       seq_clear_q, seq_clear_d;
   logic       load_colour_q, load_colour_d;
   logic [1:0] new_colour_q, new_colour_d;
   logic       led_en_q, led_en_d;
   logic [1:0] led_colour_q, led_colour_d;
   logic       win_q, win_d;
   logic       lose_q, lose_d;

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         round_q       <= '0;
         idx_q         <= '0;
         cnt_q         <= '0;
         seq_clear_q   <= 1'b0;
         load_colour_q <= 1'b0;
         new_colour_q  <= '0;
         led_en_q      <= 1'b0;
         led_colour_q  <= '0;
         win_q         <= 1'b0;
         lose_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         round_q       <= round_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         seq_clear_q   <= seq_clear_d;
         load_colour_q <= load_colour_d;
         new_colour_q  <= new_colour_d;
         led_en_q      <= led_en_d;
         led_colour_q  <= led_colour_d;
         win_q         <= win_d;
         lose_q        <= lose_d;
      end
   end

   // Next-state logic; outputs are decoded from the next state so they line up with it.
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         S_IDLE, S_WIN, S_LOSE: begin
            if (start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            round_d = '0;
            idx_d   = 6'd1;
            cnt_d   = '0;
            state_d = S_ADD;
         end
         S_ADD: begin
            if (round_q < MAX_ROUND) round_d = round_q + 6'd1;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            // History has absorbed the new colour; start playback at the oldest slot.
            idx_d   = round_q;
            cnt_d   = '0;
            state_d = S_SHOW;
         end
         S_SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (idx_q == 6'd1) begin
                  idx_d   = round_q;
                  state_d = S_WAIT_IN;
               end else begin
                  idx_d   = idx_q - 6'd1;
                  state_d = S_SHOW;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_IN: begin
            // A press in the timeout cycle wins over the timeout.
            if (btn_valid) begin
               cnt_d = '0;
               if (btn_colour == segment[idx_q]) begin
                  if (idx_q > 6'd1)              idx_d   = idx_q - 6'd1;
                  else if (round_q >= MAX_ROUND) state_d = S_WIN;
                  else                           state_d = S_ADD;
               end else begin
                  state_d = S_LOSE;
               end
            end else if (cnt_q == TO_LAST) begin
               cnt_d   = '0;
               state_d = S_LOSE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      seq_clear_d   = (state_d == S_CLEAR);
      load_colour_d = (state_d == S_ADD);
      new_colour_d  = (state_d == S_ADD) ? rand_colour : 2'd0;
      led_en_d      = (state_d == S_SHOW);
      led_colour_d  = (state_d == S_SHOW) ? segment[idx_d] : 2'd0;
      win_d         = (state_d == S_WIN);
      lose_d        = (state_d == S_LOSE);
   end

   assign seq_clear   = seq_clear_q;
   assign load_colour = load_colour_q;
   assign new_colour  = new_colour_q;
   assign led_en      = led_en_q;
   assign led_colour  = led_colour_q;
   assign round       = round_q;
   assign win         = win_q;
   assign lose        = lose_q;

endmodule

// File: tb/tb_playback_controller.sv
// Directed bench for playback_controller with a small colour-history model attached.
module tb_playback_controller;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [32:0][1:0] hist;
   logic [1:0]       rand_colour;
   logic             btn_valid;
   logic [1:0]       btn_colour;
   logic             seq_clear;
   logic             load_colour;
   logic [1:0]       new_colour;
   logic             led_en;
   logic [1:0]       led_colour;
   logic [5:0]       round;
   logic             win;
   logic             lose;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   playback_controller #(
      .SHOW_CYCLES    (2),
      .GAP_CYCLES     (1),
      .TIMEOUT_CYCLES (8),
      .MAX_LEN        (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .segment     (hist),
      .rand_colour (rand_colour),
      .btn_valid   (btn_valid),
      .btn_colour  (btn_colour),
      .seq_clear   (seq_clear),
      .load_colour (load_colour),
      .new_colour  (new_colour),
      .led_en      (led_en),
      .led_colour  (led_colour),
      .round       (round),
      .win         (win),
      .lose        (lose)
   );

   // Colour history: clear on seq_clear, shift newest into slot 1 on load_colour.
   always @(posedge clk) begin
      if (reset)            hist <= '0;
      else if (seq_clear)   hist <= '0;
      else if (load_colour) hist <= {hist[31:1], new_colour, 2'b00};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Two lit cycles of colour c followed by one dark cycle.
   task automatic chk_show(input string tag, input logic [1:0] c);
      step();
      chk({tag, "_en0"},  32'(led_en), 1);
      chk({tag, "_col0"}, 32'(led_colour), 32'(c));
      step();
      chk({tag, "_en1"},  32'(led_en), 1);
      chk({tag, "_col1"}, 32'(led_colour), 32'(c));
      step();
      chk({tag, "_gap_en"},  32'(led_en), 0);
      chk({tag, "_gap_col"}, 32'(led_colour), 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; rand_colour = 2'd0;
      btn_valid = 1'b0; btn_colour = 2'd0;
      step(); step();
      chk("rst_seq_clear", 32'(seq_clear), 0);
      chk("rst_load",      32'(load_colour), 0);
      chk("rst_new",       32'(new_colour), 0);
      chk("rst_led_en",    32'(led_en), 0);
      chk("rst_led_col",   32'(led_colour), 0);
      chk("rst_round",     32'(round), 0);
      chk("rst_win",       32'(win), 0);
      chk("rst_lose",      32'(lose), 0);
      reset = 1'b0;
      step();
      chk("idle_no_clear", 32'(seq_clear), 0);

      // First round: clear, append 2, play it back, enter WAIT_IN.
      start = 1'b1; rand_colour = 2'd2;
      step();
      chk("g1_clear",       32'(seq_clear), 1);
      chk("g1_clear_round", 32'(round), 0);
      start = 1'b0;
      step();
      chk("g1_load",        32'(load_colour), 1);
      chk("g1_new",         32'(new_colour), 2);
      chk("g1_clear_pulse", 32'(seq_clear), 0);
      step();
      chk("g1_settle_load", 32'(load_colour), 0);
      chk("g1_round1",      32'(round), 1);
      chk_show("g1r1", 2'd2);
      step();
      chk("g1_wait_led", 32'(led_en), 0);
      chk("g1_wait_lose", 32'(lose), 0);

      // Correct press, append 1, playback oldest first: 2 then 1.
      btn_valid = 1'b1; btn_colour = 2'd2; rand_colour = 2'd1;
      step();
      chk("g1_add2_load", 32'(load_colour), 1);
      chk("g1_add2_new",  32'(new_colour), 1);
      btn_valid = 1'b0;
      step();
      chk("g1_round2", 32'(round), 2);
      chk_show("g1r2a", 2'd2);
      chk_show("g1r2b", 2'd1);
      step();

      // Press 2 then 1 at MAX_LEN: WIN, held, then a new game.
      btn_valid = 1'b1; btn_colour = 2'd2;
      step();
      chk("g1_mid_win",  32'(win), 0);
      chk("g1_mid_lose", 32'(lose), 0);
      btn_colour = 2'd1;
      step();
      chk("g1_win", 32'(win), 1);
      btn_valid = 1'b0;
      step();
      chk("g1_win_held", 32'(win), 1);
      chk("g1_win_led",  32'(led_en), 0);
      start = 1'b1; rand_colour = 2'd3;
      step();
      chk("g2_clear",     32'(seq_clear), 1);
      chk("g2_win_drop",  32'(win), 0);
      start = 1'b0;
      step();
      chk("g2_round0", 32'(round), 0);
      chk("g2_load",   32'(load_colour), 1);
      chk("g2_new",    32'(new_colour), 3);
      step();
      chk("g2_round1", 32'(round), 1);
      chk_show("g2r1", 2'd3);
      step();

      // Build round 2 (3, 0) then press a wrong first colour: LOSE.
      btn_valid = 1'b1; btn_colour = 2'd3; rand_colour = 2'd0;
      step();
      chk("g2_add2_load", 32'(load_colour), 1);
      btn_valid = 1'b0;
      step();
      chk("g2_round2", 32'(round), 2);
      chk_show("g2r2a", 2'd3);
      chk_show("g2r2b", 2'd0);
      step();
      btn_valid = 1'b1; btn_colour = 2'd1;
      step();
      chk("g2_lose", 32'(lose), 1);
      btn_colour = 2'd3;
      step();
      chk("g2_lose_held",  32'(lose), 1);
      chk("g2_lose_round", 32'(round), 2);
      chk("g2_lose_load",  32'(load_colour), 0);
      btn_valid = 1'b0;

      // Timeout: eight idle WAIT_IN cycles lose.
      start = 1'b1; rand_colour = 2'd1;
      step();
      start = 1'b0;
      step(); step();
      chk_show("g3r1", 2'd1);
      step();
      repeat (7) step();
      chk("g3_no_lose_7", 32'(lose), 0);
      step();
      chk("g3_timeout", 32'(lose), 1);

      // Matching press in the eighth cycle beats the timeout.
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      chk_show("g4r1", 2'd1);
      step();
      repeat (7) step();
      btn_valid = 1'b1; btn_colour = 2'd1; rand_colour = 2'd2;
      step();
      chk("g4_press_lose", 32'(lose), 0);
      chk("g4_press_add",  32'(load_colour), 1);
      btn_valid = 1'b0;
      step();
      chk("g4_round2", 32'(round), 2);

      // Presses and start during SHOW are ignored; reset mid-SHOW.
      step();
      chk("g4_show_en",  32'(led_en), 1);
      chk("g4_show_col", 32'(led_colour), 1);
      btn_valid = 1'b1; btn_colour = 2'd3; start = 1'b1;
      step();
      chk("g4_ign_en",    32'(led_en), 1);
      chk("g4_ign_lose",  32'(lose), 0);
      chk("g4_ign_clear", 32'(seq_clear), 0);
      btn_valid = 1'b0; start = 1'b0;
      step();
      step();
      chk("g4_show2_col", 32'(led_colour), 2);
      reset = 1'b1;
      step();
      chk("mid_rst_led",   32'(led_en), 0);
      chk("mid_rst_col",   32'(led_colour), 0);
      chk("mid_rst_round", 32'(round), 0);
      chk("mid_rst_clear", 32'(seq_clear), 0);
      start = 1'b1;
      step();
      chk("rst_over_start", 32'(seq_clear), 0);
      reset = 1'b0; start = 1'b0;
      step();
      chk("post_rst_idle", 32'(seq_clear), 0);
      start = 1'b1;
      step();
      chk("post_rst_start", 32'(seq_clear), 1);
      start = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
